// File: rtl/reg_xfer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : reg_xfer_pkg
// Purpose : Shared types and constants for the register-transfer scheduler:
//           FSM state encoding, read/write opcode values and default sizes.
// Ports   : none (package)
// Config  : none
// Revision: 1.0 - initial release
// ============================================================================
package reg_xfer_pkg;

  localparam int NREGS_DEF = 16;
  localparam int IDXW_DEF  = 4;

  // req_wr encoding per requester
  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_WRITE  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module  : rr_arb2
// Purpose : Two-way round-robin arbiter. Combinational; the pointer and the
//           after-reset flag are owned by the caller.
// Ports   : req[1:0]  request vector
//           rr_ptr    last granted requester
//           first     no grant issued since reset (requester 0 preferred)
//           win[1:0]  one-hot winner, 0 when no request
// Config  : none
// Revision: 1.0 - initial release
// ============================================================================
module rr_arb2
  import reg_xfer_pkg::*;
(
  input  logic [1:0] req,
  input  logic       rr_ptr,
  input  logic       first,
  output logic [1:0] win
);

  always_comb begin
    win = 2'b00;
    case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      // Contention: the requester that was not served last goes next. Right
      // after reset nobody has been served, so requester 0 goes first.
      2'b11:   win = (first || rr_ptr) ? 2'b01 : 2'b10;
      default: win = 2'b00;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/reg_xfer_sched.sv
`default_nettype none
// ============================================================================
// Module  : reg_xfer_sched
// Purpose : Arbitrates register-file transfers between the control unit
//           (req 0) and the load/debug port (req 1) and sequences the one-hot
//           Rin/Rout strobes plus BAout, including the write settle time
//           needed by the two-stage register cells.
// Ports   : clk, clr            clock, synchronous active-high reset
//           req[1:0]            per-requester transfer request (level)
//           req_wr[1:0]         1 = write bus->reg, 0 = read reg->bus
//           req_idx0, req_idx1  register index per requester
//           req_ba[1:0]         base-address mode (R0 reads as zero)
//           gnt[1:0]            one-hot grant, held for the transaction
//           done[1:0]           one-cycle completion pulse
//           reg_in, reg_out     one-hot Rin / Rout strobes
//           ba_out              BAout strobe to R0
//           busy                FSM not idle
// Config  : REG_XFER_R0_GUARD_EN - when defined, writes to R0 never raise
//           reg_in[0]; sequence and timing are unchanged.
// Revision: 1.0 - initial release
// ============================================================================
module reg_xfer_sched
  import reg_xfer_pkg::*;
#(
  parameter int NREGS      = NREGS_DEF,
  parameter int IDXW       = IDXW_DEF,
  parameter int SETTLE_CYC = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [1:0]       req,
  input  logic [1:0]       req_wr,
  input  logic [IDXW-1:0]  req_idx0,
  input  logic [IDXW-1:0]  req_idx1,
  input  logic [1:0]       req_ba,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic [NREGS-1:0] reg_in,
  output logic [NREGS-1:0] reg_out,
  output logic             ba_out,
  output logic             busy
);

  // Counter holds SETTLE_CYC-1 down to 0.
  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [NREGS-1:0] ONE = NREGS'(1);

  state_t            state;
  logic              rr_ptr;
  logic              rr_first;
  logic [CW-1:0]     settle_cnt;

  logic [1:0]        win;
  logic              sel_wr;
  logic              sel_ba;
  logic [IDXW-1:0]   sel_idx;
  logic [NREGS-1:0]  sel_onehot;
  logic [NREGS-1:0]  wr_mask;

  rr_arb2 u_arb (
    .req    (req),
    .rr_ptr (rr_ptr),
    .first  (rr_first),
    .win    (win)
  );

  // Operand of the winning requester. The strobe is registered on the
  // acceptance edge, so nothing but the grant has to be kept afterwards.
  assign sel_wr     = win[1] ? req_wr[1]   : req_wr[0];
  assign sel_ba     = win[1] ? req_ba[1]   : req_ba[0];
  assign sel_idx    = win[1] ? req_idx1    : req_idx0;
  assign sel_onehot = ONE << sel_idx;

`ifdef REG_XFER_R0_GUARD_EN
  // R0 is hard-wired zero: its write enable is never raised.
  assign wr_mask = (sel_idx == '0) ? '0 : sel_onehot;
`else
  assign wr_mask = sel_onehot;
`endif

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= ST_IDLE;
      rr_ptr     <= 1'b0;
      rr_first   <= 1'b1;
      settle_cnt <= '0;
      gnt        <= 2'b00;
      done       <= 2'b00;
      reg_in     <= '0;
      reg_out    <= '0;
      ba_out     <= 1'b0;
    end else begin
      // Strobes and done are single-cycle pulses.
      done    <= 2'b00;
      reg_in  <= '0;
      reg_out <= '0;
      ba_out  <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (req != 2'b00) begin
            gnt      <= win;
            rr_ptr   <= win[1];
            rr_first <= 1'b0;
            if (sel_wr == OP_WR) begin
              reg_in <= wr_mask;
              state  <= ST_WRITE;
            end else begin
              reg_out <= sel_onehot;
              ba_out  <= sel_ba && (sel_idx == '0);
              state   <= ST_DRIVE;
            end
          end
        end

        ST_DRIVE: begin
          done  <= gnt;
          state <= ST_DONE;
        end

        ST_WRITE: begin
          settle_cnt <= CW'(SETTLE_CYC - 1);
          state      <= ST_SETTLE;
        end

        ST_SETTLE: begin
          if (settle_cnt == '0) begin
            done  <= gnt;
            state <= ST_DONE;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end

        ST_DONE: begin
          gnt   <= 2'b00;
          state <= ST_IDLE;
        end

        default: begin
          gnt   <= 2'b00;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_xfer_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_reg_xfer_sched
// Purpose : Self-checking bench for reg_xfer_sched. Expected strobe and done
//           events are queued when a request is driven and compared when the
//           scheduler produces them.
// Config  : REG_XFER_R0_GUARD_EN changes the expected R0 write strobe.
// Revision: 1.0 - initial release
// ============================================================================
module tb_reg_xfer_sched;

  localparam int NREGS  = 16;
  localparam int IDXW   = 4;
  localparam int SETTLE = 1;

  logic             clk = 1'b0;
  logic             clr;
  logic [1:0]       req, req_wr, req_ba;
  logic [IDXW-1:0]  req_idx0, req_idx1;
  logic [1:0]       gnt, done;
  logic [NREGS-1:0] reg_in, reg_out;
  logic             ba_out, busy;

  reg_xfer_sched #(.NREGS(NREGS), .IDXW(IDXW), .SETTLE_CYC(SETTLE)) dut (
    .clk      (clk),
    .clr      (clr),
    .req      (req),
    .req_wr   (req_wr),
    .req_idx0 (req_idx0),
    .req_idx1 (req_idx1),
    .req_ba   (req_ba),
    .gnt      (gnt),
    .done     (done),
    .reg_in   (reg_in),
    .reg_out  (reg_out),
    .ba_out   (ba_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  typedef struct {
    int               cyc;
    logic [NREGS-1:0] rin;
    logic [NREGS-1:0] rout;
    logic             ba;
  } strb_t;

  typedef struct {
    int       cyc;
    logic [1:0] done;
  } dn_t;

  strb_t sq[$];
  dn_t   dq[$];

  // Reference arbitration state.
  logic m_first = 1'b1;
  logic m_ptr   = 1'b0;

  function automatic logic [1:0] model_win(input logic [1:0] r);
    if (r == 2'b01) return 2'b01;
    if (r == 2'b10) return 2'b10;
    if (r == 2'b11) begin
      if (m_first) return 2'b01;
      return (m_ptr == 1'b0) ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  // Queue the expected events of a transaction whose strobe cycle is s.
  task automatic expect_txn(input int s, input logic [1:0] w, input logic [1:0] wr,
                            input logic [IDXW-1:0] i0, input logic [IDXW-1:0] i1,
                            input logic [1:0] ba, input bit with_done);
    logic             wrb, bab;
    logic [IDXW-1:0]  idx;
    logic [NREGS-1:0] one;
    strb_t            es;
    dn_t              ed;
    wrb = w[1] ? wr[1] : wr[0];
    bab = w[1] ? ba[1] : ba[0];
    idx = w[1] ? i1 : i0;
    one = 1;
    one = one << idx;
    es.cyc = s;
    if (wrb) begin
      es.rin  = one;
`ifdef REG_XFER_R0_GUARD_EN
      if (idx == 0) es.rin = '0;
`endif
      es.rout = '0;
      es.ba   = 1'b0;
      ed.cyc  = s + 1 + SETTLE;
    end else begin
      es.rin  = '0;
      es.rout = one;
      es.ba   = bab && (idx == 0);
      ed.cyc  = s + 1;
    end
    ed.done = w;
    if (es.rin != 0 || es.rout != 0) sq.push_back(es);
    if (with_done) dq.push_back(ed);
    m_ptr   = w[1];
    m_first = 1'b0;
  endtask

  // Scoreboard side: compare whatever the DUT emits against the queues.
  strb_t gs;
  dn_t   gd;
  always @(negedge clk) begin
    if ((reg_in | reg_out) != 0 || ba_out) begin
      if (sq.size() == 0) begin
        check("unexpected_strobe", {reg_in, reg_out}, 32'h0);
      end else begin
        gs = sq.pop_front();
        check("strobe_cycle", cyc, gs.cyc);
        check("reg_in", {16'h0, reg_in}, {16'h0, gs.rin});
        check("reg_out", {16'h0, reg_out}, {16'h0, gs.rout});
        check("ba_out", {31'h0, ba_out}, {31'h0, gs.ba});
      end
    end
    if (done != 0) begin
      if (dq.size() == 0) begin
        check("unexpected_done", {30'h0, done}, 32'h0);
      end else begin
        gd = dq.pop_front();
        check("done_cycle", cyc, gd.cyc);
        check("done", {30'h0, done}, {30'h0, gd.done});
        check("gnt_at_done", {30'h0, gnt}, {30'h0, gd.done});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 40 && busy; k++) tick();
    check("idle_reached", {31'h0, busy}, 32'h0);
    tick();
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_gnt"},  {30'h0, gnt},  32'h0);
    check({tag, "_done"}, {30'h0, done}, 32'h0);
    check({tag, "_rin"},  {16'h0, reg_in},  32'h0);
    check({tag, "_rout"}, {16'h0, reg_out}, 32'h0);
    check({tag, "_ba"},   {31'h0, ba_out},  32'h0);
    check({tag, "_busy"}, {31'h0, busy},    32'h0);
  endtask

  // Single request from idle, dropped after the acceptance edge.
  task automatic xfer(input logic [1:0] r, input logic [1:0] wr,
                      input logic [IDXW-1:0] i0, input logic [IDXW-1:0] i1,
                      input logic [1:0] ba);
    int c;
    req = r; req_wr = wr; req_idx0 = i0; req_idx1 = i1; req_ba = ba;
    c = cyc;
    expect_txn(c + 1, model_win(r), wr, i0, i1, ba, 1'b1);
    tick();
    req = 2'b00;
    wait_idle();
  endtask

  initial begin
    int c;
    clr = 1'b1; req = 0; req_wr = 0; req_ba = 0; req_idx0 = 0; req_idx1 = 0;
    repeat (2) tick();
    check_quiet("reset");
    clr = 1'b0;
    tick();

    // Read from requester 0, R5; grant held across DRIVE and DONE.
    req = 2'b01; req_wr = 2'b00; req_idx0 = 4'd5; req_idx1 = 4'd0; req_ba = 2'b00;
    c = cyc;
    expect_txn(c + 1, model_win(2'b01), 2'b00, 4'd5, 4'd0, 2'b00, 1'b1);
    tick();
    req = 2'b00;
    check("read_gnt_n1", {30'h0, gnt}, 32'h1);
    check("read_busy_n1", {31'h0, busy}, 32'h1);
    tick();
    check("read_gnt_n2", {30'h0, gnt}, 32'h1);
    tick();
    check("read_gnt_clear", {30'h0, gnt}, 32'h0);
    wait_idle();

    // Write from requester 1 into R3.
    xfer(2'b10, 2'b10, 4'd0, 4'd3, 2'b00);

    // Contention held for three grants: 0, 1, 0.
    req = 2'b11; req_wr = 2'b00; req_idx0 = 4'd2; req_idx1 = 4'd9; req_ba = 2'b00;
    c = cyc;
    for (int t = 0; t < 3; t++)
      expect_txn(c + 1 + 3 * t, model_win(2'b11), 2'b00, 4'd2, 4'd9, 2'b00, 1'b1);
    for (int k = 0; k < 20 && cyc < c + 7; k++) tick();
    check("contention_cycle", cyc, c + 7);
    req = 2'b00;
    wait_idle();

    // Base-address read of R0.
    xfer(2'b01, 2'b00, 4'd0, 4'd0, 2'b01);

    // Write to R0 (strobe depends on the guard build).
    xfer(2'b01, 2'b01, 4'd0, 4'd0, 2'b00);

    // ba on a write is ignored.
    xfer(2'b10, 2'b10, 4'd0, 4'd12, 2'b10);

    // Reset in the middle of a write: strobe seen, then no done.
    req = 2'b10; req_wr = 2'b10; req_idx0 = 4'd0; req_idx1 = 4'd7; req_ba = 2'b00;
    c = cyc;
    expect_txn(c + 1, model_win(2'b10), 2'b10, 4'd0, 4'd7, 2'b00, 1'b0);
    tick();
    req = 2'b00;
    clr = 1'b1;
    tick();
    check_quiet("midwrite_reset");
    tick();
    clr = 1'b0;
    m_first = 1'b1;
    m_ptr   = 1'b0;
    repeat (5) tick();
    check("post_reset_busy", {31'h0, busy}, 32'h0);

    // After reset, contention again favours requester 0.
    xfer(2'b11, 2'b01, 4'd4, 4'd6, 2'b00);
    xfer(2'b11, 2'b00, 4'd4, 4'd6, 2'b00);

    // Randomised traffic.
    for (int n = 0; n < 12; n++)
      xfer(2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           2'($urandom_range(0, 3)));

    repeat (3) tick();
    check("strobe_queue_empty", sq.size(), 0);
    check("done_queue_empty", dq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
